// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// Select constants are also used by the RF_WR_ARB_PROTECT_EN write filter.
package rf_pkg;

    localparam int RF_SEL_W   = 5;
    localparam int RF_DATA_W  = 32;
    localparam int RF_ENTRY_W = RF_SEL_W + RF_DATA_W;

    localparam logic [4:0] RF_SEL_LINE_STATUS = 5'd9;
    localparam logic [4:0] RF_SEL_INPUT       = 5'd10;
    localparam logic [4:0] RF_SEL_R31         = 5'd31;
    localparam logic [4:0] RF_NUM_GEN         = 5'd9;

    typedef enum logic [0:0] {
        CPU_PRI   = 1'b0,
        AUX_FORCE = 1'b1
    } rf_state_e;

    // Status registers are never writable; the aux port may only reach r0 and r31.
    function automatic logic rf_sel_blocked(input logic [4:0] sel, input logic from_aux);
        logic blocked;
        if ((sel == RF_SEL_LINE_STATUS) || (sel == RF_SEL_INPUT)) begin
            blocked = 1'b1;
        end else if (from_aux) begin
            blocked = ((sel != 5'd0) && (sel < RF_NUM_GEN)) ||
                      ((sel > RF_SEL_INPUT) && (sel != RF_SEL_R31));
        end else begin
            blocked = 1'b0;
        end
        return blocked;
    endfunction

endpackage

// File: rtl/rf_wr_fifo.sv
// Synchronous FIFO for queued auxiliary register-file writes.
// Push is ignored when full and pop is ignored when empty; the read port shows the head.
module rf_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == CNT_W'(0));
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Pointer and occupancy tracking; power-of-two depth makes pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/rf_wr_arb.sv
// Register-file write-port arbiter: CPU fixed priority, queued aux writes with starvation relief.
// Optional write filter enabled by defining RF_WR_ARB_PROTECT_EN.
module rf_wr_arb
    import rf_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_wr_en,
    input  logic [RF_SEL_W-1:0]  cpu_wr_sel,
    input  logic [RF_DATA_W-1:0] cpu_wr_data,
    output logic                 cpu_stall,
    input  logic                 aux_valid,
    output logic                 aux_ready,
    input  logic [RF_SEL_W-1:0]  aux_sel,
    input  logic [RF_DATA_W-1:0] aux_data,
    output logic                 write,
    output logic [RF_SEL_W-1:0]  writeregsel,
    output logic [RF_DATA_W-1:0] writedata,
    output logic                 err
);

    rf_state_e                   r_state;
    logic [3:0]                  r_starve_cnt;
    logic                        r_write;
    logic [RF_SEL_W-1:0]         r_sel;
    logic [RF_DATA_W-1:0]        r_data;
    logic                        r_err;
    logic [RF_ENTRY_W-1:0]       w_head;
    logic                        w_full;
    logic                        w_empty;
    logic [$clog2(FIFO_DEPTH):0] w_count;
    logic                        w_grant_cpu;
    logic                        w_grant_aux;
    logic [RF_SEL_W-1:0]         w_grant_sel;
    logic [RF_DATA_W-1:0]        w_grant_data;
    logic                        w_drop;

    rf_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RF_ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (aux_valid),
        .i_pop   (w_grant_aux),
        .i_wdata ({aux_sel, aux_data}),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Stall and ready depend only on state and occupancy so requesters see no loop.
    assign cpu_stall = (r_state == AUX_FORCE);
    assign aux_ready = ~w_full;

    // Grant selection.
    always_comb begin
        w_grant_cpu = 1'b0;
        w_grant_aux = 1'b0;
        if (r_state == AUX_FORCE) begin
            w_grant_aux = ~w_empty;
        end else if (cpu_wr_en) begin
            w_grant_cpu = 1'b1;
        end else begin
            w_grant_aux = ~w_empty;
        end
        w_grant_sel  = w_grant_cpu ? cpu_wr_sel  : w_head[RF_ENTRY_W-1:RF_DATA_W];
        w_grant_data = w_grant_cpu ? cpu_wr_data : w_head[RF_DATA_W-1:0];
    end

`ifdef RF_WR_ARB_PROTECT_EN
    assign w_drop = (w_grant_cpu | w_grant_aux) & rf_sel_blocked(w_grant_sel, w_grant_aux);
`else
    assign w_drop = 1'b0;
`endif

    // Arbitration FSM with starvation counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= CPU_PRI;
            r_starve_cnt <= 4'd0;
        end else begin
            case (r_state)
                CPU_PRI: begin
                    if (w_grant_aux || (w_count == '0)) begin
                        r_starve_cnt <= 4'd0;
                    end else if (w_grant_cpu) begin
                        r_starve_cnt <= r_starve_cnt + 4'd1;
                        if ((r_starve_cnt + 4'd1) == 4'(STARVE_LIMIT)) r_state <= AUX_FORCE;
                    end else begin
                        r_starve_cnt <= r_starve_cnt;
                    end
                end
                AUX_FORCE: begin
                    r_starve_cnt <= 4'd0;
                    r_state      <= CPU_PRI;
                end
                default: begin
                    r_starve_cnt <= 4'd0;
                    r_state      <= CPU_PRI;
                end
            endcase
        end
    end

    // Registered write port; a filtered write is consumed but only raises err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write <= 1'b0;
            r_sel   <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_write <= (w_grant_cpu | w_grant_aux) & ~w_drop;
            r_err   <= w_drop;
            if ((w_grant_cpu | w_grant_aux) && !w_drop) begin
                r_sel  <= w_grant_sel;
                r_data <= w_grant_data;
            end
        end
    end

    assign write       = r_write;
    assign writeregsel = r_sel;
    assign writedata   = r_data;
    assign err         = r_err;

endmodule

// File: tb/tb_rf_wr_arb.sv
// Self-checking bench for rf_wr_arb against a queue-based reference model.
module tb_rf_wr_arb;

    localparam int LIMIT = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_wr_en = 1'b0;
    logic [4:0]  cpu_wr_sel = 5'd0;
    logic [31:0] cpu_wr_data = 32'd0;
    logic        cpu_stall;
    logic        aux_valid = 1'b0;
    logic        aux_ready;
    logic [4:0]  aux_sel = 5'd0;
    logic [31:0] aux_data = 32'd0;
    logic        write;
    logic [4:0]  writeregsel;
    logic [31:0] writedata;
    logic        err;

    int errors = 0;
    int checks = 0;

    logic [36:0] mq[$];
    int          m_starve;
    bit          m_force;
    logic        m_write;
    logic [4:0]  m_sel;
    logic [31:0] m_data;
    logic        m_err;
    bit          saw_full;

    rf_wr_arb #(.STARVE_LIMIT(LIMIT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cpu_wr_en(cpu_wr_en), .cpu_wr_sel(cpu_wr_sel), .cpu_wr_data(cpu_wr_data),
        .cpu_stall(cpu_stall),
        .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_sel(aux_sel), .aux_data(aux_data),
        .write(write), .writeregsel(writeregsel), .writedata(writedata), .err(err)
    );

    always #5 clk = ~clk;

    function automatic bit blocked(input logic [4:0] s, input bit from_aux);
`ifdef RF_WR_ARB_PROTECT_EN
        return (s == 5'd9) || (s == 5'd10) || (from_aux && (s != 5'd0) && (s != 5'd31));
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_clear();
        mq.delete();
        m_starve = 0;
        m_force  = 1'b0;
        m_write  = 1'b0;
        m_sel    = 5'd0;
        m_data   = 32'd0;
        m_err    = 1'b0;
    endtask

    // One clock of stimulus: starts just after a rising edge, ends 1 time unit after the next.
    task automatic cycle(input logic ce, input logic [4:0] cs, input logic [31:0] cd,
                         input logic av, input logic [4:0] as_, input logic [31:0] ad);
        bit          g_cpu, g_aux, blk, ready_m;
        logic [4:0]  gs;
        logic [31:0] gd;
        logic [36:0] head;
        cpu_wr_en = ce; cpu_wr_sel = cs; cpu_wr_data = cd;
        aux_valid = av; aux_sel = as_; aux_data = ad;
        @(negedge clk);
        ready_m = (mq.size() < DEPTH);
        if (!ready_m) saw_full = 1'b1;
        checks++;
        if (aux_ready !== ready_m) begin
            errors++; $display("FAIL aux_ready: got %b expected %b", aux_ready, ready_m);
        end
        if (m_force) begin
            if (ce) begin
                checks++;
                if (cpu_stall !== 1'b1) begin
                    errors++; $display("FAIL cpu_stall_force: got %b expected 1", cpu_stall);
                end
            end
        end else begin
            checks++;
            if (cpu_stall !== 1'b0) begin
                errors++; $display("FAIL cpu_stall_idle: got %b expected 0", cpu_stall);
            end
        end
        g_cpu = 1'b0; g_aux = 1'b0; head = '0;
        if (m_force) begin
            g_aux = (mq.size() > 0);
            m_force = 1'b0;
            m_starve = 0;
        end else if (ce) begin
            g_cpu = 1'b1;
            if (mq.size() > 0) begin
                m_starve++;
                if (m_starve == LIMIT) m_force = 1'b1;
            end else begin
                m_starve = 0;
            end
        end else begin
            g_aux = (mq.size() > 0);
            m_starve = 0;
        end
        if (g_aux) head = mq.pop_front();
        if (av && ready_m) mq.push_back({as_, ad});
        gs  = g_cpu ? cs : head[36:32];
        gd  = g_cpu ? cd : head[31:0];
        blk = (g_cpu || g_aux) && blocked(gs, g_aux);
        m_write = (g_cpu || g_aux) && !blk;
        m_err   = blk;
        if (m_write) begin
            m_sel = gs; m_data = gd;
        end
        @(posedge clk); #1;
        checks++;
        if (write !== m_write || err !== m_err) begin
            errors++; $display("FAIL write_err: got write=%b err=%b expected write=%b err=%b",
                               write, err, m_write, m_err);
        end
        checks++;
        if (writeregsel !== m_sel || writedata !== m_data) begin
            errors++; $display("FAIL sel_data: got %0d/%h expected %0d/%h",
                               writeregsel, writedata, m_sel, m_data);
        end
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        model_clear();
        @(posedge clk); #1;
        checks++;
        if (write !== 1'b0 || writeregsel !== 5'd0 || writedata !== 32'd0 || err !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: got %b/%0d/%h/%b expected 0/0/0/0",
                               write, writeregsel, writedata, err);
        end
        checks++;
        if (cpu_stall !== 1'b0 || aux_ready !== 1'b1) begin
            errors++; $display("FAIL reset_handshake: got stall=%b ready=%b expected 0/1",
                               cpu_stall, aux_ready);
        end
    endtask

    task automatic test_cpu_write();
        cycle(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        checks++;
        if (write !== 1'b1 || writeregsel !== 5'd3 || writedata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL cpu_write: got %b/%0d/%h expected 1/3/deadbeef",
                               write, writeregsel, writedata);
        end
        idle();
    endtask

    task automatic test_aux_latency();
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd31, 32'h1234);
        checks++;
        if (write !== 1'b0) begin
            errors++; $display("FAIL aux_early: got write=%b expected 0", write);
        end
        idle();
        checks++;
        if (write !== 1'b1 || writeregsel !== 5'd31 || writedata !== 32'h1234) begin
            errors++; $display("FAIL aux_latency: got %b/%0d/%h expected 1/31/1234",
                               write, writeregsel, writedata);
        end
        idle();
    endtask

    task automatic test_starvation();
        int stalls;
        stalls = 0;
        saw_full = 1'b0;
        for (int i = 0; i < 4; i++) cycle(1'b1, 5'd2, 32'h100 + i, 1'b1, 5'd0, 32'hA0 + i);
        for (int i = 0; i < 22; i++) begin
            if (m_force) stalls++;
            cycle(1'b1, 5'd4, 32'h200 + i, 1'b0, 5'd0, 32'd0);
        end
        checks++;
        if (!saw_full || stalls != 4 || mq.size() != 0) begin
            errors++; $display("FAIL starvation: full=%b stalls=%0d left=%0d expected 1/4/0",
                               saw_full, stalls, mq.size());
        end
        idle();
    endtask

    task automatic test_push_pop_wrap();
        cycle(1'b1, 5'd1, 32'h11, 1'b1, 5'd31, 32'hB0);
        cycle(1'b1, 5'd1, 32'h12, 1'b1, 5'd31, 32'hB1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hC0 + i);
        checks++;
        if (mq.size() != 2) begin
            errors++; $display("FAIL push_pop_count: got %0d expected 2", mq.size());
        end
        repeat (4) idle();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 5'd7, 32'h300 + i, (i < 3) ? 1'b1 : 1'b0, 5'd31, 32'hD0 + i);
        checks++;
        if (write !== 1'b1 || mq.size() != 3) begin
            errors++; $display("FAIL mid_setup: got write=%b queued=%0d expected 1/3", write, mq.size());
        end
        cpu_wr_en = 1'b0; aux_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (write !== 1'b0) begin
            errors++; $display("FAIL async_clear: got write=%b expected 0", write);
        end
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        model_clear();
        @(posedge clk); #1;
        checks++;
        if (aux_ready !== 1'b1) begin
            errors++; $display("FAIL post_reset_ready: got %b expected 1", aux_ready);
        end
        repeat (2) idle();
    endtask

    task automatic test_protect();
        cycle(1'b1, 5'd9, 32'h9999, 1'b0, 5'd0, 32'd0);
        idle();
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h5555);
        repeat (2) idle();
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd31, 32'h3131);
        repeat (2) idle();
    endtask

    task automatic test_random(input int n, input int cpu_pct);
        for (int i = 0; i < n; i++)
            cycle(($urandom_range(0, 99) < cpu_pct), 5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
        repeat (3 * (LIMIT + 1) * DEPTH) idle();
    endtask

    initial begin
        model_clear();
        test_reset();
        test_cpu_write();
        test_aux_latency();
        test_starvation();
        test_push_pop_wrap();
        test_reset_mid();
        test_protect();
        test_random(400, 50);
        test_random(200, 100);
        test_random(200, 10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
